// File: rtl/lock_arbiter.sv
// lock_arbiter: schedules the single lock chamber between vessels waiting on
// the arrival (outer) side and the departure (inner) side. Pending requests
// are counted per side and served round-robin. A one-cycle grant pulse starts
// an interlock transfer. No further grant is issued until the interlock has
// gone busy, reported cycleDone, and a fixed settle time has passed.
//
// Pulse protocol: arriveReq, leaveReq and cycleDone are single-cycle strobes
// that are sampled on one posedge each. grantArrive, grantLeave, dropped and
// startFail are single-cycle registered strobes. There is no back-pressure:
// a request that arrives while its queue is full is lost, and dropped flags it.
module lock_arbiter #(
  parameter int QW       = 3,
  parameter int START_TO = 16,
  parameter int SETTLE   = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          arriveReq,
  input  logic          leaveReq,
  input  logic          lockBusy,
  input  logic          cycleDone,
  output logic          grantArrive,
  output logic          grantLeave,
  output logic [QW-1:0] arriveCount,
  output logic [QW-1:0] leaveCount,
  output logic          arriveFull,
  output logic          leaveFull,
  output logic          dropped,
  output logic          startFail,
  output logic [1:0]    stateLeds
);

  localparam logic [QW-1:0] MAX_COUNT = '1;
  localparam int TW = $clog2(START_TO + SETTLE + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    WAIT_BUSY = 2'b01,
    BUSY      = 2'b10,
    SETTLING  = 2'b11
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic          lastLeave;      // 1: the last side served was departure
  logic          prevLastLeave;  // value of lastLeave before the current grant
  logic          grantedArrive;  // side of the in-flight grant

  logic          canGrant;
  logic          pickArrive;
  logic          decArrive;
  logic          decLeave;
  logic          timeout;
  logic          restoreArrive;
  logic          restoreLeave;
  logic [QW-1:0] nextArrive;
  logic [QW-1:0] nextLeave;
  logic          dropArrive;
  logic          dropLeave;

  // The FSM state register doubles as the LED debug output.
  assign stateLeds = state;

  // Grant selection, start timeout, and the next value of each queue counter.
  always_comb begin
    canGrant      = (state == IDLE) && !lockBusy &&
                    ((arriveCount != '0) || (leaveCount != '0));
    pickArrive    = (arriveCount != '0) && ((leaveCount == '0) || lastLeave);
    decArrive     = canGrant && pickArrive;
    decLeave      = canGrant && !pickArrive;
    timeout       = (state == WAIT_BUSY) && !lockBusy &&
                    (timer == TW'(START_TO - 1));
    restoreArrive = timeout && grantedArrive;
    restoreLeave  = timeout && !grantedArrive;

    nextArrive = arriveCount;
    dropArrive = 1'b0;
    if (arriveReq && !decArrive) begin
      if (arriveCount == MAX_COUNT) dropArrive = 1'b1;
      else                          nextArrive = arriveCount + 1'b1;
    end else if (!arriveReq && decArrive) begin
      nextArrive = arriveCount - 1'b1;
    end
    if (restoreArrive && (nextArrive != MAX_COUNT)) nextArrive = nextArrive + 1'b1;

    nextLeave = leaveCount;
    dropLeave = 1'b0;
    if (leaveReq && !decLeave) begin
      if (leaveCount == MAX_COUNT) dropLeave = 1'b1;
      else                         nextLeave = leaveCount + 1'b1;
    end else if (!leaveReq && decLeave) begin
      nextLeave = leaveCount - 1'b1;
    end
    if (restoreLeave && (nextLeave != MAX_COUNT)) nextLeave = nextLeave + 1'b1;
  end

  // Registered FSM, counters and all output strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      timer         <= '0;
      lastLeave     <= 1'b1;
      prevLastLeave <= 1'b1;
      grantedArrive <= 1'b0;
      arriveCount   <= '0;
      leaveCount    <= '0;
      arriveFull    <= 1'b0;
      leaveFull     <= 1'b0;
      grantArrive   <= 1'b0;
      grantLeave    <= 1'b0;
      dropped       <= 1'b0;
      startFail     <= 1'b0;
    end else begin
      arriveCount <= nextArrive;
      leaveCount  <= nextLeave;
      arriveFull  <= (nextArrive == MAX_COUNT);
      leaveFull   <= (nextLeave == MAX_COUNT);
      grantArrive <= decArrive;
      grantLeave  <= decLeave;
      dropped     <= dropArrive | dropLeave;
      startFail   <= timeout;

      case (state)
        IDLE: begin
          if (canGrant) begin
            prevLastLeave <= lastLeave;
            lastLeave     <= !pickArrive;
            grantedArrive <= pickArrive;
            timer         <= '0;
            state         <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          if (lockBusy) begin
            state <= BUSY;
          end else if (timeout) begin
            // The transfer never started, so it does not count as served.
            lastLeave <= prevLastLeave;
            state     <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        BUSY: begin
          if (cycleDone) begin
            timer <= '0;
            state <= SETTLING;
          end
        end
        SETTLING: begin
          if (timer == TW'(SETTLE - 1)) state <= IDLE;
          else                          timer <= timer + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lock_arbiter.sv
// tb_lock_arbiter: directed scenarios plus a randomized run for lock_arbiter.
// The reference model below tracks queues, turn order and the interlock
// phase with plain integers and is stepped on every clock edge.
module tb_lock_arbiter;

  localparam int QW       = 3;
  localparam int MAXC     = 7;
  localparam int START_TO = 16;
  localparam int SETTLE   = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          arriveReq;
  logic          leaveReq;
  logic          lockBusy;
  logic          cycleDone;
  logic          grantArrive;
  logic          grantLeave;
  logic [QW-1:0] arriveCount;
  logic [QW-1:0] leaveCount;
  logic          arriveFull;
  logic          leaveFull;
  logic          dropped;
  logic          startFail;
  logic [1:0]    stateLeds;

  int checks = 0;
  int errors = 0;

  // Scoreboard of expected grant order, encoded {grantLeave, grantArrive}.
  logic [1:0] exp_q[$];

  // Reference model state: index 0 = arrival side, 1 = departure side.
  int mCnt[2];
  int mLast;
  int mPrevLast;
  int mPhase;   // 0 idle, 1 waiting for busy, 2 busy, 3 settling
  int mLeft;    // cycles left in the current timed phase
  int mSide;
  bit mGrant[2];
  bit mDrop;
  bit mFail;

  lock_arbiter #(.QW(QW), .START_TO(START_TO), .SETTLE(SETTLE)) dut (
    .clk         (clk),
    .reset       (reset),
    .arriveReq   (arriveReq),
    .leaveReq    (leaveReq),
    .lockBusy    (lockBusy),
    .cycleDone   (cycleDone),
    .grantArrive (grantArrive),
    .grantLeave  (grantLeave),
    .arriveCount (arriveCount),
    .leaveCount  (leaveCount),
    .arriveFull  (arriveFull),
    .leaveFull   (leaveFull),
    .dropped     (dropped),
    .startFail   (startFail),
    .stateLeds   (stateLeds)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic model_step();
    int dec;
    int restore;
    bit req[2];
    req[0]    = arriveReq;
    req[1]    = leaveReq;
    dec       = -1;
    restore   = -1;
    mGrant[0] = 1'b0;
    mGrant[1] = 1'b0;
    mDrop     = 1'b0;
    mFail     = 1'b0;
    if (reset) begin
      mCnt[0] = 0; mCnt[1] = 0;
      mLast = 1; mPrevLast = 1; mPhase = 0; mLeft = 0; mSide = 0;
      return;
    end
    case (mPhase)
      0: if (!lockBusy && (mCnt[0] > 0 || mCnt[1] > 0)) begin
           if (mCnt[0] > 0 && mCnt[1] > 0) mSide = 1 - mLast;
           else                            mSide = (mCnt[0] > 0) ? 0 : 1;
           mPrevLast     = mLast;
           mLast         = mSide;
           mGrant[mSide] = 1'b1;
           dec           = mSide;
           mPhase        = 1;
           mLeft         = START_TO;
         end
      1: if (lockBusy) mPhase = 2;
         else begin
           mLeft--;
           if (mLeft == 0) begin
             mFail = 1'b1; restore = mSide; mLast = mPrevLast; mPhase = 0;
           end
         end
      2: if (cycleDone) begin mPhase = 3; mLeft = SETTLE; end
      default: begin mLeft--; if (mLeft == 0) mPhase = 0; end
    endcase
    for (int s = 0; s < 2; s++) begin
      if (req[s] && dec != s) begin
        if (mCnt[s] == MAXC) mDrop = 1'b1;
        else                 mCnt[s]++;
      end else if (!req[s] && dec == s) begin
        mCnt[s]--;
      end
      if (restore == s && mCnt[s] < MAXC) mCnt[s]++;
    end
  endtask

  // Advance one clock: the model sees the same inputs the DUT samples.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    reset = 1'b1; arriveReq = 1'b0; leaveReq = 1'b0;
    lockBusy = 1'b0; cycleDone = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  // Get the chamber into BUSY by serving one departure request.
  task automatic enter_busy_via_leave();
    leaveReq = 1'b1; tick();
    leaveReq = 1'b0; tick();
    lockBusy = 1'b1; tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    checks++;
    if ({grantArrive, grantLeave, dropped, startFail, arriveFull, leaveFull} !== 6'b0) begin
      errors++;
      $display("FAIL reset_strobes got %b want 000000",
               {grantArrive, grantLeave, dropped, startFail, arriveFull, leaveFull});
    end
    checks++;
    if (arriveCount !== 3'd0 || leaveCount !== 3'd0) begin
      errors++;
      $display("FAIL reset_counts got %0d/%0d want 0/0", arriveCount, leaveCount);
    end
    checks++;
    if (stateLeds !== 2'b00) begin
      errors++; $display("FAIL reset_state got %b want 00", stateLeds);
    end
  endtask

  task automatic test_single_arrive();
    apply_reset();
    arriveReq = 1'b1; tick();
    arriveReq = 1'b0;
    checks++;
    if (arriveCount !== 3'd1 || grantArrive !== 1'b0) begin
      errors++;
      $display("FAIL single_queued count %0d grant %b want 1 0", arriveCount, grantArrive);
    end
    tick();
    checks++;
    if (grantArrive !== 1'b1 || grantLeave !== 1'b0 || arriveCount !== 3'd0 || stateLeds !== 2'b01) begin
      errors++;
      $display("FAIL single_grant gA %b gL %b count %0d state %b want 1 0 0 01",
               grantArrive, grantLeave, arriveCount, stateLeds);
    end
    tick();
    checks++;
    if (grantArrive !== 1'b0) begin
      errors++; $display("FAIL single_grant_width got %b want 0", grantArrive);
    end
    lockBusy = 1'b1; tick();
    checks++;
    if (stateLeds !== 2'b10) begin
      errors++; $display("FAIL single_busy state %b want 10", stateLeds);
    end
    cycleDone = 1'b1; lockBusy = 1'b0; tick();
    cycleDone = 1'b0;
    checks++;
    if (stateLeds !== 2'b11) begin
      errors++; $display("FAIL single_settle_entry state %b want 11", stateLeds);
    end
    for (int i = 0; i < SETTLE - 1; i++) begin
      tick();
      checks++;
      if (stateLeds !== 2'b11) begin
        errors++; $display("FAIL single_settle_hold cycle %0d state %b want 11", i, stateLeds);
      end
    end
    tick();
    checks++;
    if (stateLeds !== 2'b00) begin
      errors++; $display("FAIL single_settle_exit state %b want 00", stateLeds);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] got;
    logic [1:0] want;
    apply_reset();
    enter_busy_via_leave();
    for (int i = 0; i < 2; i++) begin
      arriveReq = 1'b1; leaveReq = 1'b1; tick();
    end
    arriveReq = 1'b0; leaveReq = 1'b0;
    checks++;
    if (arriveCount !== 3'd2 || leaveCount !== 3'd2) begin
      errors++; $display("FAIL rr_preload got %0d/%0d want 2/2", arriveCount, leaveCount);
    end
    exp_q.push_back(2'b01); exp_q.push_back(2'b10);
    exp_q.push_back(2'b01); exp_q.push_back(2'b10);
    for (int g = 0; g < 4; g++) begin
      cycleDone = 1'b1; lockBusy = 1'b0; tick();
      cycleDone = 1'b0;
      for (int i = 0; i < SETTLE; i++) tick();
      tick();
      got  = {grantLeave, grantArrive};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++; $display("FAIL rr_grant %0d got %b want %b", g, got, want);
      end
      lockBusy = 1'b1; tick(); tick();
    end
    checks++;
    if (arriveCount !== 3'd0 || leaveCount !== 3'd0) begin
      errors++; $display("FAIL rr_drain got %0d/%0d want 0/0", arriveCount, leaveCount);
    end
    lockBusy = 1'b0;
  endtask

  task automatic test_saturation();
    apply_reset();
    enter_busy_via_leave();
    for (int i = 0; i < 8; i++) begin
      arriveReq = 1'b1; tick();
      checks++;
      if (int'(arriveCount) !== ((i + 1 > MAXC) ? MAXC : i + 1) || dropped !== (i == 7) ||
          arriveFull !== (i >= 6)) begin
        errors++;
        $display("FAIL sat_req %0d count %0d drop %b full %b", i, arriveCount, dropped, arriveFull);
      end
    end
    arriveReq = 1'b0; tick();
    checks++;
    if (dropped !== 1'b0 || arriveCount !== 3'd7 || arriveFull !== 1'b1) begin
      errors++;
      $display("FAIL sat_hold drop %b count %0d full %b want 0 7 1", dropped, arriveCount, arriveFull);
    end
    lockBusy = 1'b0;
  endtask

  task automatic test_simultaneous();
    apply_reset();
    arriveReq = 1'b1; tick();
    tick();
    arriveReq = 1'b0;
    checks++;
    if (grantArrive !== 1'b1 || arriveCount !== 3'd1) begin
      errors++;
      $display("FAIL simul_req_grant grant %b count %0d want 1 1", grantArrive, arriveCount);
    end
  endtask

  task automatic test_start_timeout();
    apply_reset();
    arriveReq = 1'b1; tick();
    arriveReq = 1'b0; tick();
    for (int i = 1; i < START_TO; i++) begin
      tick();
      checks++;
      if (startFail !== 1'b0 || stateLeds !== 2'b01) begin
        errors++; $display("FAIL to_wait %0d fail %b state %b want 0 01", i, startFail, stateLeds);
      end
    end
    tick();
    checks++;
    if (startFail !== 1'b1 || arriveCount !== 3'd1 || stateLeds !== 2'b00) begin
      errors++;
      $display("FAIL to_fire fail %b count %0d state %b want 1 1 00", startFail, arriveCount, stateLeds);
    end
    tick();
    checks++;
    if (grantArrive !== 1'b1 || startFail !== 1'b0 || arriveCount !== 3'd0) begin
      errors++;
      $display("FAIL to_regrant grant %b fail %b count %0d want 1 0 0", grantArrive, startFail, arriveCount);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    enter_busy_via_leave();
    for (int i = 0; i < 3; i++) begin
      arriveReq = 1'b1; leaveReq = (i < 2); tick();
    end
    arriveReq = 1'b0; leaveReq = 1'b0;
    checks++;
    if (arriveCount !== 3'd3 || leaveCount !== 3'd2 || stateLeds !== 2'b10) begin
      errors++;
      $display("FAIL mid_setup got %0d/%0d state %b want 3/2 10", arriveCount, leaveCount, stateLeds);
    end
    reset = 1'b1; tick();
    reset = 1'b0; lockBusy = 1'b0;
    checks++;
    if ({grantArrive, grantLeave, dropped, startFail, arriveFull, leaveFull, arriveCount, leaveCount, stateLeds} !== 14'b0) begin
      errors++;
      $display("FAIL mid_reset counts %0d/%0d state %b strobes %b", arriveCount, leaveCount, stateLeds,
               {grantArrive, grantLeave, dropped, startFail, arriveFull, leaveFull});
    end
    cycleDone = 1'b1; tick();
    cycleDone = 1'b0; tick();
    checks++;
    if (stateLeds !== 2'b00 || grantArrive !== 1'b0 || grantLeave !== 1'b0) begin
      errors++;
      $display("FAIL mid_stray_done state %b grants %b%b want 00 00", stateLeds, grantArrive, grantLeave);
    end
  endtask

  task automatic test_random();
    logic [13:0] got;
    logic [13:0] want;
    int mode;
    apply_reset();
    mode = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 200 == 0) mode = $urandom_range(0, 2);
      reset     = ($urandom_range(0, 499) == 0);
      arriveReq = ($urandom_range(0, 3) == 0);
      leaveReq  = ($urandom_range(0, 3) == 0);
      cycleDone = ($urandom_range(0, 7) == 0);
      case (mode)
        0:       lockBusy = ($urandom_range(0, 3) == 0);
        1:       lockBusy = ($urandom_range(0, 3) != 0);
        default: lockBusy = 1'b0;
      endcase
      tick();
      want = {mGrant[0], mGrant[1], 3'(mCnt[0]), 3'(mCnt[1]), mCnt[0] == MAXC, mCnt[1] == MAXC,
              mDrop, mFail, 2'(mPhase)};
      got  = {grantArrive, grantLeave, arriveCount, leaveCount, arriveFull, leaveFull,
              dropped, startFail, stateLeds};
      checks++;
      if (got !== want) begin
        errors++; $display("FAIL random cycle %0d got %b want %b", cyc, got, want);
      end
      checks++;
      if (grantArrive === 1'b1 && grantLeave === 1'b1) begin
        errors++; $display("FAIL random_dual_grant cycle %0d got 11 want at most one", cyc);
      end
    end
    reset = 1'b0; arriveReq = 1'b0; leaveReq = 1'b0; cycleDone = 1'b0; lockBusy = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b1; arriveReq = 1'b0; leaveReq = 1'b0;
    lockBusy = 1'b0; cycleDone = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_arrive();
    test_round_robin();
    test_saturation();
    test_simultaneous();
    test_start_timeout();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
